// File: rtl/sensor_ctrl_ring.sv
// sensor_ctrl_ring: captures sensor words into a DEPTH-word buffer.
// Stop-on-full or ring-overwrite capture, watermark interrupt, oldest-first
// read index, live sample count and sticky overwrite flag.
// Optional build macro SCTRL_DROP_CNT_EN adds a saturating 16-bit counter of
// samples lost to ring overwrite or offered while stalled on full.
//
// Sensor handshake: sensor_en is the controller's ready, sensor_ready is the
// sensor's valid; a sample transfers on every rising clk edge where both are
// high. sensor_en depends only on current inputs and registered state, never
// on sensor_ready, so the sensor may present a sample at any time.
module sensor_ctrl_ring #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sctrl_en,
  input  logic              sctrl_clear,
  input  logic              sctrl_mode,
  input  logic [AW:0]       sctrl_wmark,
  input  logic [AW-1:0]     sctrl_addr,
  input  logic              sensor_ready,
  input  logic [DATA_W-1:0] sensor_out,
  output logic              sctrl_interrupt,
  output logic [DATA_W-1:0] sctrl_out,
  output logic [AW:0]       sctrl_count,
  output logic              sctrl_ovf,
  output logic              sensor_en
`ifdef SCTRL_DROP_CNT_EN
  ,
  output logic [15:0]       sctrl_drop_cnt
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic              full;
  logic              accept;
  logic              irq_next;
  logic [AW-1:0]     rd_base;
  logic [AW-1:0]     rd_idx;
  logic              rd_valid;

  assign full = (count == DEPTH_C);

  // Capture request: held off while clearing, in reset, or full in stop mode.
  assign sensor_en = rst_n & sctrl_en & ~sctrl_clear & ~(full & ~sctrl_mode);
  assign accept    = sensor_en & sensor_ready;

  // Next sample count: clear wins, otherwise count up and saturate at DEPTH.
  always_comb begin
    count_next = count;
    if (sctrl_clear) begin
      count_next = '0;
    end else if (accept && !full) begin
      count_next = count + 1'b1;
    end
  end

  // Interrupt condition: stalled full in stop mode, or watermark reached.
  assign irq_next = (full & ~sctrl_mode) |
                    ((sctrl_wmark != '0) && (count_next >= sctrl_wmark));

  // Buffer, pointers, count, overflow flag and registered interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      count           <= '0;
      sctrl_ovf       <= 1'b0;
      sctrl_interrupt <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (sctrl_clear) begin
      wr_ptr          <= '0;
      count           <= '0;
      sctrl_ovf       <= 1'b0;
      sctrl_interrupt <= 1'b0;
    end else begin
      count           <= count_next;
      sctrl_interrupt <= irq_next;
      if (accept) begin
        mem[wr_ptr] <= sensor_out;
        wr_ptr      <= wr_ptr + 1'b1;
        // accept while full can only happen in ring mode: oldest word lost
        if (full) begin
          sctrl_ovf <= 1'b1;
        end
      end
    end
  end

  // Oldest-first read: once full the oldest word sits at the write pointer.
  assign rd_base     = full ? wr_ptr : '0;
  assign rd_idx      = rd_base + sctrl_addr;
  assign rd_valid    = ({1'b0, sctrl_addr} < count);
  assign sctrl_out   = rd_valid ? mem[rd_idx] : '0;
  assign sctrl_count = count;

`ifdef SCTRL_DROP_CNT_EN
  logic drop_evt;

  assign drop_evt = (accept & full) |
                    (sctrl_en & sensor_ready & full & ~sctrl_mode);

  // Saturating count of samples lost to overwrite or refused while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sctrl_drop_cnt <= '0;
    end else if (sctrl_clear) begin
      sctrl_drop_cnt <= '0;
    end else if (drop_evt && (sctrl_drop_cnt != 16'hFFFF)) begin
      sctrl_drop_cnt <= sctrl_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sensor_ctrl_ring.sv
// tb_sensor_ctrl_ring: directed bench for sensor_ctrl_ring with a 64-deep
// and an 8-deep instance sharing control and sensor stimulus.
module tb_sensor_ctrl_ring;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        en, clr, mode, rdy;
  logic [31:0] data;

  // 64-deep instance
  logic [6:0]  wm64;
  logic [5:0]  addr64;
  logic        irq64, ovf64, sen64;
  logic [31:0] out64;
  logic [6:0]  cnt64;

  // 8-deep instance
  logic [3:0]  wm8;
  logic [2:0]  addr8;
  logic        irq8, ovf8, sen8;
  logic [31:0] out8;
  logic [3:0]  cnt8;

`ifdef SCTRL_DROP_CNT_EN
  logic [15:0] drop64, drop8;
`endif

  sensor_ctrl_ring #(.DATA_W(32), .DEPTH(64)) dut64 (
    .clk             (clk),
    .rst_n           (rst_n),
    .sctrl_en        (en),
    .sctrl_clear     (clr),
    .sctrl_mode      (mode),
    .sctrl_wmark     (wm64),
    .sctrl_addr      (addr64),
    .sensor_ready    (rdy),
    .sensor_out      (data),
    .sctrl_interrupt (irq64),
    .sctrl_out       (out64),
    .sctrl_count     (cnt64),
    .sctrl_ovf       (ovf64),
    .sensor_en       (sen64)
`ifdef SCTRL_DROP_CNT_EN
    ,
    .sctrl_drop_cnt  (drop64)
`endif
  );

  sensor_ctrl_ring #(.DATA_W(32), .DEPTH(8)) dut8 (
    .clk             (clk),
    .rst_n           (rst_n),
    .sctrl_en        (en),
    .sctrl_clear     (clr),
    .sctrl_mode      (mode),
    .sctrl_wmark     (wm8),
    .sctrl_addr      (addr8),
    .sensor_ready    (rdy),
    .sensor_out      (data),
    .sctrl_interrupt (irq8),
    .sctrl_out       (out8),
    .sctrl_count     (cnt8),
    .sctrl_ovf       (ovf8),
    .sensor_en       (sen8)
`ifdef SCTRL_DROP_CNT_EN
    ,
    .sctrl_drop_cnt  (drop8)
`endif
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table for the 8-deep instance ----------------
  // Inputs are driven for one cycle; expectations are the outputs seen
  // during that cycle, before its closing clock edge.
  typedef struct {
    logic        en, clr, mode, rdy;
    logic [31:0] data;
    logic [2:0]  addr;
    logic [3:0]  wm;
    logic [3:0]  e_cnt;
    logic [31:0] e_out;
    logic        e_irq, e_ovf, e_sen;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic v_en, v_clr, v_mode, v_rdy,
                              input logic [31:0] v_data, input logic [2:0] v_addr,
                              input logic [3:0] v_wm, input logic [3:0] v_cnt,
                              input logic [31:0] v_out,
                              input logic v_irq, v_ovf, v_sen);
    vec_t v;
    v.en = v_en; v.clr = v_clr; v.mode = v_mode; v.rdy = v_rdy;
    v.data = v_data; v.addr = v_addr; v.wm = v_wm;
    v.e_cnt = v_cnt; v.e_out = v_out;
    v.e_irq = v_irq; v.e_ovf = v_ovf; v.e_sen = v_sen;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //             en clr md rdy data    addr wm  | cnt out   irq ovf sen
    // ring fill with 1..11: oldest becomes 4, newest 11
    tbl[0]  = mk(1, 0, 1, 1, 32'd1,  3'd0, 4'd0, 4'd0, 32'd0,  0, 0, 1);
    tbl[1]  = mk(1, 0, 1, 1, 32'd2,  3'd0, 4'd0, 4'd1, 32'd1,  0, 0, 1);
    tbl[2]  = mk(1, 0, 1, 1, 32'd3,  3'd0, 4'd0, 4'd2, 32'd1,  0, 0, 1);
    tbl[3]  = mk(1, 0, 1, 1, 32'd4,  3'd0, 4'd0, 4'd3, 32'd1,  0, 0, 1);
    tbl[4]  = mk(1, 0, 1, 1, 32'd5,  3'd0, 4'd0, 4'd4, 32'd1,  0, 0, 1);
    tbl[5]  = mk(1, 0, 1, 1, 32'd6,  3'd0, 4'd0, 4'd5, 32'd1,  0, 0, 1);
    tbl[6]  = mk(1, 0, 1, 1, 32'd7,  3'd0, 4'd0, 4'd6, 32'd1,  0, 0, 1);
    tbl[7]  = mk(1, 0, 1, 1, 32'd8,  3'd0, 4'd0, 4'd7, 32'd1,  0, 0, 1);
    tbl[8]  = mk(1, 0, 1, 1, 32'd9,  3'd0, 4'd0, 4'd8, 32'd1,  0, 0, 1);
    tbl[9]  = mk(1, 0, 1, 1, 32'd10, 3'd0, 4'd0, 4'd8, 32'd2,  0, 1, 1);
    tbl[10] = mk(1, 0, 1, 1, 32'd11, 3'd0, 4'd0, 4'd8, 32'd3,  0, 1, 1);
    tbl[11] = mk(1, 0, 1, 0, 32'd0,  3'd0, 4'd0, 4'd8, 32'd4,  0, 1, 1);
    tbl[12] = mk(1, 0, 1, 0, 32'd0,  3'd7, 4'd0, 4'd8, 32'd11, 0, 1, 1);
    tbl[13] = mk(1, 0, 1, 0, 32'd0,  3'd3, 4'd0, 4'd8, 32'd7,  0, 1, 1);
    // ring -> stop while full: capture stops, data kept, stall interrupt
    tbl[14] = mk(1, 0, 0, 1, 32'h55, 3'd0, 4'd0, 4'd8, 32'd4,  0, 1, 0);
    tbl[15] = mk(1, 0, 0, 0, 32'd0,  3'd0, 4'd0, 4'd8, 32'd4,  1, 1, 0);
    // stop -> ring while full: overwrite oldest (4) with 12
    tbl[16] = mk(1, 0, 1, 1, 32'd12, 3'd0, 4'd0, 4'd8, 32'd4,  1, 1, 1);
    tbl[17] = mk(1, 0, 1, 0, 32'd0,  3'd0, 4'd0, 4'd8, 32'd5,  0, 1, 1);
    // watermark 7 fires, watermark 9 (> DEPTH) never fires
    tbl[18] = mk(1, 0, 1, 0, 32'd0,  3'd0, 4'd7, 4'd8, 32'd5,  0, 1, 1);
    tbl[19] = mk(1, 0, 1, 0, 32'd0,  3'd0, 4'd7, 4'd8, 32'd5,  1, 1, 1);
    tbl[20] = mk(1, 0, 1, 0, 32'd0,  3'd0, 4'd9, 4'd8, 32'd5,  1, 1, 1);
    tbl[21] = mk(1, 0, 1, 0, 32'd0,  3'd0, 4'd9, 4'd8, 32'd5,  0, 1, 1);
    // clear with a sample offered: no write, everything zeroed
    tbl[22] = mk(1, 1, 1, 1, 32'h77, 3'd0, 4'd0, 4'd8, 32'd5,  0, 1, 0);
    tbl[23] = mk(0, 0, 1, 0, 32'd0,  3'd0, 4'd0, 4'd0, 32'd0,  0, 0, 0);
    tbl[24] = mk(1, 1, 1, 1, 32'h99, 3'd0, 4'd0, 4'd0, 32'd0,  0, 0, 0);
    tbl[25] = mk(1, 0, 1, 1, 32'h21, 3'd0, 4'd0, 4'd0, 32'd0,  0, 0, 1);
    tbl[26] = mk(1, 0, 1, 0, 32'd0,  3'd0, 4'd0, 4'd1, 32'h21, 0, 0, 1);
    // disabled: offered sample ignored, reads still valid
    tbl[27] = mk(0, 0, 1, 1, 32'h33, 3'd0, 4'd0, 4'd1, 32'h21, 0, 0, 0);
    tbl[28] = mk(0, 0, 1, 0, 32'd0,  3'd0, 4'd0, 4'd1, 32'h21, 0, 0, 0);

    // ---------------- reset ----------------
    rst_n = 1'b0;
    en = 0; clr = 0; mode = 0; rdy = 0; data = '0;
    wm64 = '0; addr64 = '0; wm8 = '0; addr8 = '0;
    #2;
    chk("reset count8", 32'(cnt8), 32'd0);
    chk("reset irq8",   32'(irq8), 32'd0);
    chk("reset ovf8",   32'(ovf8), 32'd0);
    chk("reset sen8",   32'(sen8), 32'd0);
    chk("reset out8",   out8,      32'd0);
    chk("reset count64", 32'(cnt64), 32'd0);
    #10;
    rst_n = 1'b1;
    step();

    // ---------------- table-driven sequence ----------------
    for (int i = 0; i < NV; i++) begin
      en = tbl[i].en; clr = tbl[i].clr; mode = tbl[i].mode; rdy = tbl[i].rdy;
      data = tbl[i].data; addr8 = tbl[i].addr; wm8 = tbl[i].wm;
      #1;
      chk($sformatf("v%0d count", i), 32'(cnt8), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d out", i),   out8,      tbl[i].e_out);
      chk($sformatf("v%0d irq", i),   32'(irq8), 32'(tbl[i].e_irq));
      chk($sformatf("v%0d ovf", i),   32'(ovf8), 32'(tbl[i].e_ovf));
      chk($sformatf("v%0d sen", i),   32'(sen8), 32'(tbl[i].e_sen));
      step();
    end

    // ---------------- asynchronous reset mid-capture ----------------
    en = 1; clr = 1; mode = 1; rdy = 0; wm8 = 4'd2; addr8 = '0;
    step();
    clr = 0;
    for (int i = 0; i < 3; i++) begin
      rdy = 1; data = 32'hA0 + 32'(i);
      step();
    end
    rdy = 0;
    chk("pre-reset count8", 32'(cnt8), 32'd3);
    chk("pre-reset irq8",   32'(irq8), 32'd1);
    chk("pre-reset out8",   out8,      32'hA0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset count8", 32'(cnt8), 32'd0);
    chk("async reset irq8",   32'(irq8), 32'd0);
    chk("async reset sen8",   32'(sen8), 32'd0);
    chk("async reset out8",   out8,      32'd0);
    en = 0; wm8 = '0;
    #3;
    rst_n = 1'b1;
    step();
    chk("post-reset out8",   out8,      32'd0);
    chk("post-reset count8", 32'(cnt8), 32'd0);

    // ---------------- stop mode, 64 deep, 64 samples ----------------
    en = 1; clr = 1; mode = 0; rdy = 0; wm64 = '0;
    step();
    clr = 0;
    for (int i = 0; i < 64; i++) begin
      rdy = 1; data = 32'h100 + 32'(i);
      #1;
      chk($sformatf("fill64 sen %0d", i), 32'(sen64), 32'd1);
      step();
    end
    rdy = 0;
    #1;
    chk("full64 count", 32'(cnt64), 32'd64);
    chk("full64 sen",   32'(sen64), 32'd0);
    step();
    chk("full64 irq", 32'(irq64), 32'd1);
    addr64 = 6'd0;  #1; chk("full64 addr0",  out64, 32'h100);
    addr64 = 6'd63; #1; chk("full64 addr63", out64, 32'h13F);
    addr64 = 6'd32; #1; chk("full64 addr32", out64, 32'h120);
    chk("full64 ovf", 32'(ovf64), 32'd0);

    // ---------------- watermark 5, stop mode ----------------
    addr64 = '0; wm64 = 7'd5; clr = 1;
    step();
    clr = 0;
    chk("wm clear irq", 32'(irq64), 32'd0);
    for (int i = 0; i < 5; i++) begin
      rdy = 1; data = 32'h200 + 32'(i);
      step();
      rdy = 0;
      if (i == 3) chk("wm irq after 4", 32'(irq64), 32'd0);
    end
    chk("wm irq after 5", 32'(irq64), 32'd1);
    chk("wm count 5",     32'(cnt64), 32'd5);
    clr = 1;
    step();
    clr = 0;
    chk("wm irq after clear",   32'(irq64), 32'd0);
    chk("wm count after clear", 32'(cnt64), 32'd0);

`ifdef SCTRL_DROP_CNT_EN
    // ---------------- drop counter, 8 deep, stop mode ----------------
    wm64 = '0; clr = 1; mode = 0;
    step();
    clr = 0;
    for (int i = 0; i < 10; i++) begin
      rdy = 1; data = 32'h300 + 32'(i);
      step();
    end
    rdy = 0;
    chk("drop8 count", 32'(drop8), 32'd2);
    chk("drop8 fill",  32'(cnt8),  32'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
